pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage P7 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).
//  Resolves RAW hazards from Tuse (ID) versus Tnew (EX, MEM), tracks mult/div busy time, and issues
//  exception/eret flush plus PC redirect. Sits beside the hazard-unit slot; drives register enables/clears.
// PARAMETERS
//  MULT_CYC  5             busy cycles after mult/multu start
//  DIV_CYC   10            busy cycles after div/divu start
//  EXC_VEC   32'h0000_4180 handler entry address
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, synchronous, active-high
//  id_rs/id_rt   in   5   GRF read addresses of the instruction in ID
//  id_tuse_rs/rt in   2   cycles until ID instr needs rs/rt (3 = not used)
//  id_md_use     in   1   ID instr is mult/div/mfhi/mflo/mthi/mtlo
//  ex_grfwe      in   1   EX instr writes GRF
//  ex_wa         in   5   EX write address
//  ex_tnew       in   2   EX Tnew, already stage-adjusted
//  mem_grfwe     in   1   MEM instr writes GRF
//  mem_wa        in   5   MEM write address
//  mem_tnew      in   2   MEM Tnew, already stage-adjusted
//  ex_md_start   in   1   EX instr starts mult/div this cycle
//  ex_md_div     in   1   qualifies start: 1 = div, 0 = mult
//  mem_exc       in   1   MEM exception or interrupt (IntReq) taken
//  mem_eret      in   1   eret in MEM
//  epc           in   32  current EPC
//  stall_pc      out  1   hold PC
//  stall_d       out  1   hold IF/ID
//  bubble_e      out  1   clear ID/EX (insert nop)
//  flush_all     out  1   clear IF/ID, ID/EX, EX/MEM, MEM/WB
//  redirect      out  1   load PC from redirect_pc
//  redirect_pc   out  32  EXC_VEC or epc
//  md_busy       out  1   mult/div unit occupied
// BEHAVIOUR
//  Reset: state=RUN, md_cnt=0; all outputs 0, redirect_pc=0.
//  RAW stall (rs; rt identical): rs!=0 && ((ex_grfwe && ex_wa==rs && ex_tnew>tuse_rs) ||
//    (mem_grfwe && mem_wa==rs && mem_tnew>tuse_rs)). $0 never stalls.
//  md_cnt (5 bits): ex_md_start loads DIV_CYC or MULT_CYC; else decrements to 0 and holds.
//    md_busy = ex_md_start || md_cnt!=0. md stall = id_md_use && md_busy.
//  stall = RAW || md stall -> stall_pc=stall_d=bubble_e=1, combinational, same cycle.
//  FSM RUN: mem_exc -> flush_all=1, redirect=1, redirect_pc=EXC_VEC, next DRAIN;
//    else mem_eret -> flush_all=1, redirect=1, redirect_pc=epc, next DRAIN; else stall logic.
//  FSM DRAIN (exactly 1 cycle): stall outputs forced 0, mem_exc/mem_eret ignored (MEM holds a
//    bubble), redirect=0; next RUN.
//  Priority: reset > mem_exc > mem_eret > stall. While flush_all=1 stalls are 0.
//  Exception does not clear md_cnt: an issued mult/div runs to completion.
//  ex_md_start while md_cnt!=0 cannot occur (ID md stall) and reloads the counter if forced.
//  Reset mid-operation: md_cnt->0, state->RUN in the next cycle.
// STRUCTURE
//  Shared package pipe_pkg: TUSE_NONE=2'd3, state encodings RUN/DRAIN, EXC_VEC, MULT_CYC/DIV_CYC.
//  Sub-module md_busy_counter (load/decrement counter, md_busy out); remainder is flat logic.
// TESTING
//  1. lw $1 (EX tnew=2), ID addu uses $1 tuse=1 -> stall 1 cycle, bubble_e=1, then release.
//  2. mult in EX, mflo next in ID -> md stall 5 cycles; div -> 10 cycles; md_busy drops after count.
//  3. RAW on $0 with ex_tnew=2 -> no stall.
//  4. mem_exc during md stall -> flush_all=redirect=1, redirect_pc=0x4180; next cycle DRAIN,
//     no stall; md_cnt keeps counting down.
//  5. mem_eret with epc=0x3010 -> redirect_pc=0x3010, flush_all=1; mem_exc+mem_eret together -> 0x4180.
//  6. reset asserted at md_cnt=7 -> next cycle md_busy=0, all outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the P7 pipeline hazard sequencer: FSM states, timing defaults
// and the RAW hazard test applied to each GRF source operand.
package pipe_pkg;
    localparam logic [1:0]  TUSE_NONE = 2'd3;
    localparam int          MD_CNT_W  = 5;
    localparam int          MULT_CYC  = 5;
    localparam int          DIV_CYC   = 10;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } hz_state_e;

    // A producer stalls ID when its result arrives later than the consumer needs it.
    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       ex_we,
        input logic [4:0] ex_wa,
        input logic [1:0] ex_tnew,
        input logic       mem_we,
        input logic [4:0] mem_wa,
        input logic [1:0] mem_tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               ((ex_we  && (ex_wa  == src) && (ex_tnew  > tuse)) ||
                (mem_we && (mem_wa == src) && (mem_tnew > tuse)));
    endfunction
endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the operation latency on start, then counts down to zero.
module md_busy_counter #(
    parameter int MULT_CYC = pipe_pkg::MULT_CYC,
    parameter int DIV_CYC  = pipe_pkg::DIV_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);
    import pipe_pkg::*;

    logic [MD_CNT_W-1:0] md_cnt_reg;
    logic [MD_CNT_W-1:0] md_cnt_next;

    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (start) begin
            md_cnt_next = is_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
        end else if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_reg <= '0;
        end else begin
            md_cnt_reg <= md_cnt_next;
        end
    end

    // The start cycle itself counts as busy so a dependent instruction in ID stalls at once.
    assign md_busy = start || (md_cnt_reg != '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW and mult/div stalls, exception/eret
// flush with PC redirect, followed by one drain cycle while the flushed bubble reaches MEM.
module pipe_hazard_ctrl #(
    parameter int          MULT_CYC = pipe_pkg::MULT_CYC,
    parameter int          DIV_CYC  = pipe_pkg::DIV_CYC,
    parameter logic [31:0] EXC_VEC  = pipe_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic        id_md_use,
    input  logic        ex_grfwe,
    input  logic [4:0]  ex_wa,
    input  logic [1:0]  ex_tnew,
    input  logic        mem_grfwe,
    input  logic [4:0]  mem_wa,
    input  logic [1:0]  mem_tnew,
    input  logic        ex_md_start,
    input  logic        ex_md_div,
    input  logic        mem_exc,
    input  logic        mem_eret,
    input  logic [31:0] epc,
    output logic        stall_pc,
    output logic        stall_d,
    output logic        bubble_e,
    output logic        flush_all,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        md_busy
);
    import pipe_pkg::*;

    hz_state_e state_reg;
    hz_state_e state_next;
    logic      md_busy_raw;
    logic      raw_stall;
    logic      stall;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (ex_md_start),
        .is_div  (ex_md_div),
        .md_busy (md_busy_raw)
    );

    assign raw_stall = raw_hit(id_rs, id_tuse_rs, ex_grfwe, ex_wa, ex_tnew,
                               mem_grfwe, mem_wa, mem_tnew) ||
                       raw_hit(id_rt, id_tuse_rt, ex_grfwe, ex_wa, ex_tnew,
                               mem_grfwe, mem_wa, mem_tnew);
    assign stall     = raw_stall || (id_md_use && md_busy_raw);

    always_comb begin
        stall_pc    = 1'b0;
        stall_d     = 1'b0;
        bubble_e    = 1'b0;
        flush_all   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        md_busy     = 1'b0;
        state_next  = state_reg;
        if (!reset) begin
            md_busy = md_busy_raw;
            if (state_reg == DRAIN) begin
                state_next = RUN;
            end else if (mem_exc || mem_eret) begin
                flush_all   = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mem_exc ? EXC_VEC : epc;
                state_next  = DRAIN;
            end else begin
                stall_pc = stall;
                stall_d  = stall;
                bubble_e = stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW vector table plus mult/div, flush and reset sequences.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic [1:0]  id_tuse_rs, id_tuse_rt;
    logic        id_md_use;
    logic        ex_grfwe;
    logic [4:0]  ex_wa;
    logic [1:0]  ex_tnew;
    logic        mem_grfwe;
    logic [4:0]  mem_wa;
    logic [1:0]  mem_tnew;
    logic        ex_md_start, ex_md_div;
    logic        mem_exc, mem_eret;
    logic [31:0] epc;
    logic        stall_pc, stall_d, bubble_e, flush_all, redirect, md_busy;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_md_use(id_md_use),
        .ex_grfwe(ex_grfwe), .ex_wa(ex_wa), .ex_tnew(ex_tnew),
        .mem_grfwe(mem_grfwe), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
        .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .mem_exc(mem_exc), .mem_eret(mem_eret), .epc(epc),
        .stall_pc(stall_pc), .stall_d(stall_d), .bubble_e(bubble_e),
        .flush_all(flush_all), .redirect(redirect), .redirect_pc(redirect_pc),
        .md_busy(md_busy)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic       ex_we;
        logic [4:0] ex_wa;
        logic [1:0] ex_tnew;
        logic       mem_we;
        logic [4:0] mem_wa;
        logic [1:0] mem_tnew;
        logic       exp_stall;
    } raw_vec_t;

    raw_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        check({name, ".stall_pc"}, {31'b0, stall_pc}, {31'b0, exp});
        check({name, ".stall_d"},  {31'b0, stall_d},  {31'b0, exp});
        check({name, ".bubble_e"}, {31'b0, bubble_e}, {31'b0, exp});
    endtask

    task automatic check_flush(input string name, input logic exp, input logic [31:0] pc);
        check({name, ".flush_all"},   {31'b0, flush_all}, {31'b0, exp});
        check({name, ".redirect"},    {31'b0, redirect},  {31'b0, exp});
        check({name, ".redirect_pc"}, redirect_pc, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3; id_md_use = 1'b0;
        ex_grfwe = 1'b0; ex_wa = 5'd0; ex_tnew = 2'd0;
        mem_grfwe = 1'b0; mem_wa = 5'd0; mem_tnew = 2'd0;
        ex_md_start = 1'b0; ex_md_div = 1'b0; mem_exc = 1'b0; mem_eret = 1'b0;
        epc = 32'h0;
    endtask

    initial begin
        //              rs    rt    trs   trt   exwe  exwa  extn  mwe   mwa   mtn   stall
        vecs[0] = '{5'd1, 5'd2, 2'd1, 2'd1, 1'b1, 5'd1, 2'd2, 1'b0, 5'd0, 2'd0, 1'b1};
        vecs[1] = '{5'd1, 5'd2, 2'd1, 2'd1, 1'b1, 5'd1, 2'd1, 1'b0, 5'd0, 2'd0, 1'b0};
        vecs[2] = '{5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd0, 2'd2, 1'b1, 5'd0, 2'd2, 1'b0};
        vecs[3] = '{5'd3, 5'd5, 2'd2, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 5'd5, 2'd1, 1'b1};
        vecs[4] = '{5'd3, 5'd5, 2'd2, 2'd3, 1'b1, 5'd5, 2'd2, 1'b1, 5'd5, 2'd2, 1'b0};
        vecs[5] = '{5'd4, 5'd6, 2'd0, 2'd0, 1'b0, 5'd4, 2'd2, 1'b0, 5'd6, 2'd2, 1'b0};
        vecs[6] = '{5'd7, 5'd8, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 5'd7, 2'd2, 1'b1};
        vecs[7] = '{5'd7, 5'd8, 2'd0, 2'd0, 1'b1, 5'd9, 2'd2, 1'b1, 5'd10, 2'd2, 1'b0};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_stall("reset", 1'b0);
        check_flush("reset", 1'b0, 32'h0);
        check("reset.md_busy", {31'b0, md_busy}, 32'h0);
        reset = 1'b0;
        tick();
        $display("reset released");

        // RAW vector table, evaluated combinationally in RUN with the md unit idle
        for (int i = 0; i < 8; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_tuse_rs = vecs[i].tu_rs; id_tuse_rt = vecs[i].tu_rt;
            ex_grfwe = vecs[i].ex_we; ex_wa = vecs[i].ex_wa; ex_tnew = vecs[i].ex_tnew;
            mem_grfwe = vecs[i].mem_we; mem_wa = vecs[i].mem_wa; mem_tnew = vecs[i].mem_tnew;
            #1;
            check_stall($sformatf("raw_vec%0d", i), vecs[i].exp_stall);
            check($sformatf("raw_vec%0d.flush_all", i), {31'b0, flush_all}, 32'h0);
            $display("raw vector %0d: rs=%0d rt=%0d stall=%0b", i, id_rs, id_rt, stall_pc);
        end
        idle_inputs();
        tick();

        // lw $1 in EX, addu using $1 in ID: one stall, then lw moves to MEM with tnew=1
        id_rs = 5'd1; id_tuse_rs = 2'd1; id_rt = 5'd2; id_tuse_rt = 2'd1;
        ex_grfwe = 1'b1; ex_wa = 5'd1; ex_tnew = 2'd2;
        #1;
        check_stall("lw_use.stall", 1'b1);
        tick();
        ex_grfwe = 1'b0; ex_wa = 5'd0; ex_tnew = 2'd0;
        mem_grfwe = 1'b1; mem_wa = 5'd1; mem_tnew = 2'd1;
        #1;
        check_stall("lw_use.release", 1'b0);
        $display("lw-use sequence done");
        idle_inputs();
        tick();

        // mult then div with a dependent mfhi/mflo held in ID
        for (int op = 0; op < 2; op++) begin
            int cyc;
            cyc = (op == 0) ? 5 : 10;
            id_md_use = 1'b1; ex_md_start = 1'b1; ex_md_div = (op == 1);
            #1;
            check_stall($sformatf("md%0d.start", op), 1'b1);
            check($sformatf("md%0d.start_busy", op), {31'b0, md_busy}, 32'h1);
            tick();
            ex_md_start = 1'b0; ex_md_div = 1'b0;
            for (int k = 0; k < cyc; k++) begin
                #1;
                check_stall($sformatf("md%0d.cnt_step%0d", op, k), 1'b1);
                check($sformatf("md%0d.busy_step%0d", op, k), {31'b0, md_busy}, 32'h1);
                tick();
            end
            #1;
            check_stall($sformatf("md%0d.done", op), 1'b0);
            check($sformatf("md%0d.done_busy", op), {31'b0, md_busy}, 32'h0);
            $display("md op %0d: busy released after %0d counted cycles", op, cyc);
            idle_inputs();
            tick();
        end

        // exception during md stall: flush now, drain next cycle, counter keeps running
        id_md_use = 1'b1; ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick();
        mem_exc = 1'b1;
        #1;
        check_flush("exc_md", 1'b1, 32'h0000_4180);
        check_stall("exc_md", 1'b0);
        check("exc_md.md_busy", {31'b0, md_busy}, 32'h1);
        tick();
        #1;
        check_flush("exc_drain", 1'b0, 32'h0);
        check_stall("exc_drain", 1'b0);
        check("exc_drain.md_busy", {31'b0, md_busy}, 32'h1);
        mem_exc = 1'b0;
        tick();
        check_stall("exc_run_cnt2", 1'b1);
        tick();
        check_stall("exc_run_cnt1", 1'b1);
        tick();
        check_stall("exc_run_cnt0", 1'b0);
        check("exc_run_cnt0.md_busy", {31'b0, md_busy}, 32'h0);
        $display("exception during md stall done");
        idle_inputs();
        tick();

        // eret redirect to EPC, then exc+eret together favours the vector
        mem_eret = 1'b1; epc = 32'h0000_3010;
        #1;
        check_flush("eret", 1'b1, 32'h0000_3010);
        tick();
        mem_eret = 1'b0;
        tick();
        mem_exc = 1'b1; mem_eret = 1'b1;
        #1;
        check_flush("exc_eret", 1'b1, 32'h0000_4180);
        tick();
        idle_inputs();
        tick();
        $display("eret sequences done");

        // reset with div counter at 7: counter cleared, outputs quiet
        ex_md_start = 1'b1; ex_md_div = 1'b1; id_md_use = 1'b1;
        tick();
        ex_md_start = 1'b0; ex_md_div = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset.md_busy", {31'b0, md_busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_reset.md_busy", {31'b0, md_busy}, 32'h0);
        check_stall("post_reset", 1'b0);
        check_flush("post_reset", 1'b0, 32'h0);
        $display("reset mid-operation done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
